// File: rtl/uart_tx_pkg.sv
// Shared definitions for the UART serial blocks: state encodings, defaults,
// and the mapping from FSM state to serial line level.
package uart_tx_pkg;

    localparam int unsigned DATA_W               = 8;
    localparam int unsigned DEFAULT_CLKS_PER_BIT = 434;  // 50 MHz / 115200 baud
    localparam int unsigned DEFAULT_CNT_W        = 16;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_START = 3'd1;
    localparam logic [2:0] ST_DATA  = 3'd2;
    localparam logic [2:0] ST_STOP  = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    localparam logic [2:0] LAST_BIT_IDX = 3'(DATA_W - 1);

    // Line level driven while in a given state; only DATA depends on the payload.
    function automatic logic line_level(input logic [2:0] state, input logic lsb);
        logic level;
        case (state)
            ST_START: level = 1'b0;
            ST_DATA:  level = lsb;
            default:  level = 1'b1;
        endcase
        return level;
    endfunction

endpackage

// File: rtl/uart_tx_baud_counter.sv
// Modulo-CLKS_PER_BIT counter with synchronous clear and a wrap pulse marking
// the last cycle of each bit period; shared with the receive path.
module uart_tx_baud_counter
    import uart_tx_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int unsigned CNT_W        = DEFAULT_CNT_W
) (
    input  logic clk,
    input  logic reset,
    input  logic clear_i,
    input  logic en_i,
    output logic wrap_o
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             at_last;

    assign at_last = (cnt_q == LAST);
    assign wrap_o  = en_i && !clear_i && at_last;

    // NOTE: every variable written in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = at_last ? '0 : cnt_q + 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter: accepts a byte on tx_en while idle, shifts it out LSB
// first between a start and stop bit, then pulses tx_done for one cycle.
module uart_tx
    import uart_tx_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int unsigned CNT_W        = DEFAULT_CNT_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              tx_en,
    input  logic [DATA_W-1:0] tx_data,
    output logic              tx,
    output logic              tx_done,
    output logic              tx_busy
);

    logic [2:0]        state_q;
    logic [2:0]        state_d;
    logic [2:0]        bit_idx_q;
    logic [2:0]        bit_idx_d;
    logic [DATA_W-1:0] shift_q;
    logic [DATA_W-1:0] shift_d;
    logic              busy_q;
    logic              busy_d;
    logic              tx_q;
    logic              done_q;

    logic              baud_clear;
    logic              baud_en;
    logic              bit_end;

    assign baud_clear = (state_q == ST_IDLE);
    assign baud_en    = (state_q == ST_START) || (state_q == ST_DATA) || (state_q == ST_STOP);

    uart_tx_baud_counter #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .CNT_W        (CNT_W)
    ) u_baud (
        .clk     (clk),
        .reset   (reset),
        .clear_i (baud_clear),
        .en_i    (baud_en),
        .wrap_o  (bit_end)
    );

    always_comb begin
        state_d   = state_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        busy_d    = busy_q;
        case (state_q)
            ST_IDLE: begin
                if (tx_en) begin
                    shift_d   = tx_data;
                    bit_idx_d = '0;
                    busy_d    = 1'b1;
                    state_d   = ST_START;
                end
            end
            ST_START: begin
                if (bit_end) begin
                    bit_idx_d = '0;
                    state_d   = ST_DATA;
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    shift_d   = shift_q >> 1;
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == LAST_BIT_IDX) begin
                        state_d = ST_STOP;
                    end
                end
            end
            ST_STOP: begin
                if (bit_end) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // Line and handshake outputs are registered from the current state, so tx
    // trails the state by one cycle and tx_done lands right after the stop bit.
    // NOTE: the shift register is a handful of flops, not a memory array, and
    // is reset so an aborted frame leaves no stale payload behind.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            bit_idx_q <= '0;
            shift_q   <= '0;
            busy_q    <= 1'b0;
            tx_q      <= 1'b1;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            busy_q    <= busy_d;
            tx_q      <= line_level(state_q, shift_q[0]);
            done_q    <= (state_q == ST_DONE);
        end
    end

    assign tx      = tx_q;
    assign tx_done = done_q;
    assign tx_busy = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: table of byte frames at CLKS_PER_BIT 4, 2
// and 16, plus hand-written reset and idle sequences.
module tb_uart_tx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       en4, en2, en16;
    logic [7:0] d4, d2, d16;
    logic       tx4, tx2, tx16;
    logic       done4, done2, done16;
    logic       busy4, busy2, busy16;

    uart_tx #(.CLKS_PER_BIT(4), .CNT_W(16)) dut4 (
        .clk(clk), .reset(reset), .tx_en(en4), .tx_data(d4),
        .tx(tx4), .tx_done(done4), .tx_busy(busy4));

    uart_tx #(.CLKS_PER_BIT(2), .CNT_W(16)) dut2 (
        .clk(clk), .reset(reset), .tx_en(en2), .tx_data(d2),
        .tx(tx2), .tx_done(done2), .tx_busy(busy2));

    uart_tx #(.CLKS_PER_BIT(16), .CNT_W(16)) dut16 (
        .clk(clk), .reset(reset), .tx_en(en16), .tx_data(d16),
        .tx(tx16), .tx_done(done16), .tx_busy(busy16));

    int checks = 0;
    int errors = 0;

    typedef struct {
        string      nm;
        int         cpb;
        logic [7:0] data;
        logic [9:0] frame;   // frame[0] is the first bit on the line
        bit         keep_en;
        bit         glitch;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string nm, input logic [2:0] act, input logic [2:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: {tx,busy,done} got %b expected %b", nm, act, exp);
        end
    endtask

    function automatic logic [2:0] status(input int cpb);
        case (cpb)
            2:       return {tx2, busy2, done2};
            4:       return {tx4, busy4, done4};
            16:      return {tx16, busy16, done16};
            default: return 3'bxxx;
        endcase
    endfunction

    task automatic set_in(input int cpb, input logic en, input logic [7:0] d);
        case (cpb)
            2:       begin en2  = en; d2  = d; end
            4:       begin en4  = en; d4  = d; end
            16:      begin en16 = en; d16 = d; end
            default: ;
        endcase
    endtask

    // Called just after a negedge with the DUT idle (or in the idle cycle after DONE).
    task automatic run_frame(input string nm, input int cpb, input logic [7:0] d,
                             input logic [9:0] frame, input bit keep_en, input bit glitch);
        set_in(cpb, 1'b1, d);
        @(negedge clk);
        check({nm, " accept"}, status(cpb), 3'b110);
        set_in(cpb, keep_en, ~d);
        for (int b = 0; b < 10; b++) begin
            for (int c = 0; c < cpb; c++) begin
                @(negedge clk);
                check($sformatf("%s bit%0d cyc%0d", nm, b, c), status(cpb), {frame[b], 2'b10});
                if (glitch && b == 3 && c == 0) set_in(cpb, 1'b1, 8'hFF);
                if (glitch && b == 6 && c == 0) set_in(cpb, 1'b0, 8'hFF);
            end
        end
        @(negedge clk);
        check({nm, " done"}, status(cpb), 3'b101);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{"A5 single",      4,  8'hA5, 10'b1101001010, 1'b0, 1'b0};
        vecs[1] = '{"00 busy-ignore", 4,  8'h00, 10'b1000000000, 1'b0, 1'b1};
        vecs[2] = '{"3C held",        4,  8'h3C, 10'b1001111000, 1'b1, 1'b0};
        vecs[3] = '{"C3 held",        4,  8'hC3, 10'b1110000110, 1'b0, 1'b0};
        vecs[4] = '{"E7 cpb2",        2,  8'hE7, 10'b1111001110, 1'b0, 1'b0};
        vecs[5] = '{"E7 cpb16",       16, 8'hE7, 10'b1111001110, 1'b0, 1'b0};

        reset = 1'b1;
        set_in(2, 1'b0, 8'h00);
        set_in(4, 1'b0, 8'h00);
        set_in(16, 1'b0, 8'h00);
        #1;
        check("reset cpb4", status(4), 3'b100);
        check("reset cpb2", status(2), 3'b100);
        check("reset cpb16", status(16), 3'b100);
        repeat (3) @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check($sformatf("idle cpb4 %0d", i), status(4), 3'b100);
            check($sformatf("idle cpb2 %0d", i), status(2), 3'b100);
            check($sformatf("idle cpb16 %0d", i), status(16), 3'b100);
        end

        for (int v = 0; v < 6; v++) begin
            run_frame(vecs[v].nm, vecs[v].cpb, vecs[v].data, vecs[v].frame,
                      vecs[v].keep_en, vecs[v].glitch);
            if (!vecs[v].keep_en) begin
                for (int i = 0; i < 4; i++) begin
                    @(negedge clk);
                    check($sformatf("%s after %0d", vecs[v].nm, i), status(vecs[v].cpb), 3'b100);
                end
            end
        end

        // Reset during data bit 3 of 8'h55 (frame bit 4, tx low).
        set_in(4, 1'b1, 8'h55);
        @(negedge clk);
        check("rst55 accept", status(4), 3'b110);
        set_in(4, 1'b0, 8'h55);
        repeat (18) @(negedge clk);
        check("rst55 data bit3", status(4), 3'b010);
        #2 reset = 1'b1;
        #1 check("rst55 async", status(4), 3'b100);
        repeat (2) begin
            @(negedge clk);
            check("rst55 held", status(4), 3'b100);
        end
        reset = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            check($sformatf("rst55 no resume %0d", i), status(4), 3'b100);
        end
        run_frame("81 after reset", 4, 8'h81, 10'b1100000010, 1'b0, 1'b0);
        @(negedge clk);
        check("81 after reset idle", status(4), 3'b100);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
